hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Next-generation hazard unit for the 5-stage in-order core.
- Keeps the MEM/WB forwarding, load-use stall and branch flush functions of the current unit.
- Adds a register scoreboard for a variable-latency multiply/divide unit (MDU), including a pending-op limit and a sticky scoreboard-error flag.
- Adds a global pipeline freeze driven by the data-cache miss stall, and a saturating stall-cycle performance counter.
- Sits beside the pipeline registers; drives their stall and flush enables and the EXEC operand muxes.

Parameters:
- REG_ADDR_W, 5, register address width; register file has 2**REG_ADDR_W entries, entry 0 hardwired zero.
- MAX_PENDING, 4, maximum MDU ops in flight (1..2**REG_ADDR_W-1).
- CNT_W, 16, stall-cycle counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  reset, synchronous, active-high.
- i_rs1_addr_dec, i_rs2_addr_dec, i_rd_addr_dec  in  REG_ADDR_W  DEC source and destination registers.
- i_rs1_used_dec, i_rs2_used_dec  in  1  DEC instruction reads rs1 / rs2.
- i_reg_we_dec  in  1  DEC instruction writes rd.
- i_mdu_instr_dec  in  1  DEC instruction is an MDU op.
- i_rs1_addr_exec, i_rs2_addr_exec, i_rd_addr_exec  in  REG_ADDR_W  EXEC registers.
- i_load_instr_exec  in  1  EXEC instruction is a load.
- i_mdu_issue_exec  in  1  EXEC instruction is an MDU op; it issues this cycle.
- i_rd_addr_mem  in  REG_ADDR_W;  i_reg_we_mem  in  1.
- i_rd_addr_wb  in  REG_ADDR_W;  i_reg_we_wb  in  1.
- i_pc_src_exec  in  1  taken branch/jump resolved in EXEC.
- i_mem_stall  in  1  D-cache busy; freeze the pipeline.
- i_mdu_done  in  1  MDU writes its result to the register file this cycle.
- i_mdu_rd_addr  in  REG_ADDR_W  destination of the completing MDU op.
- i_cnt_clr  in  1  clear the stall counter.
- o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem  out  1  hold the stage register.
- o_flush_dec, o_flush_exec  out  1  bubble the stage register.
- o_forward_rs1, o_forward_rs2  out  2  operand select: 00 regfile, 01 WB, 10 MEM.
- o_pending_cnt  out  $clog2(MAX_PENDING+1)  MDU ops in flight.
- o_stall_cycles  out  CNT_W  saturating count of DEC-stall cycles.
- o_sb_err  out  1  sticky scoreboard error.

Behaviour:
- Reset (i_arst high at a clock edge) clears scoreboard, o_pending_cnt, o_stall_cycles and o_sb_err to 0; takes priority over every same-cycle event, including an in-flight i_mdu_done (that completion is dropped).
- All other outputs are combinational from the inputs and state, so they follow reset with zero latency.
- Forwarding, per source rsN:
  - 10 if i_reg_we_mem & rd_mem==rsN_exec & rd_mem!=0;
  - else 01 if i_reg_we_wb & rd_wb==rsN_exec & rd_wb!=0;
  - else 00. MEM beats WB.
- Register 0 never creates a hazard, forward or scoreboard entry.
- Hazard terms:
  - load_use = i_load_instr_exec & i_rd_addr_exec!=0 & (rs1 used & match | rs2 used & match), comparing DEC sources against i_rd_addr_exec.
  - raw_sb = a used DEC source has its scoreboard bit set, or equals i_rd_addr_exec while i_mdu_issue_exec.
  - waw_sb = i_reg_we_dec & rd_dec!=0 & the same conditions applied to rd_dec.
  - full = i_mdu_instr_dec & pending_cnt==MAX_PENDING & ~(i_mdu_done & mdu_done_valid).
  - hazard = load_use | raw_sb | waw_sb | full.
- Control priority:
  1. i_mem_stall: all four stalls=1, both flushes=0.
  2. Else i_pc_src_exec: flush_dec=flush_exec=1, all stalls=0; the branch overrides the hazard.
  3. Else hazard: stall_fetch=stall_dec=1 and flush_exec=1; stall_exec=stall_mem=0.
  4. Else everything 0.
- Issue event = i_mdu_issue_exec & ~i_mem_stall & i_rd_addr_exec!=0. Sets bit[rd_exec] and increments the count.
- Done event:
  - Valid when i_mdu_done and bit[i_mdu_rd_addr] is set: clears the bit and decrements the count.
  - A done on a clear bit, or on register 0, sets o_sb_err and leaves state unchanged.
  - Done is honoured during i_mem_stall.
  - A valid done clears its bit at the clock edge; a DEC reader sees it cleared the next cycle (no result bypass).
- Simultaneous issue and done:
  - Different registers: set one bit, clear the other, count unchanged.
  - Same register: the bit ends set, count unchanged.
- Issue while count==MAX_PENDING: ignored and sets o_sb_err; unreachable when the stall logic is correct.
- o_stall_cycles increments each cycle o_stall_dec=1 and saturates at all-ones. i_cnt_clr sets it to 0 and wins over the increment.
- o_sb_err clears only on reset.

Test Plan:
- Forwarding: MEM rd=5 we=1, WB rd=5 we=1, rs1_exec=5 → fwd_rs1=10. With MEM we=0 → 01. With rd=0 and rs1=0 → 00.
- Load-use: load rd=7 in EXEC, DEC rs2=7 used → stall_fetch/dec=1, flush_exec=1 for one cycle, o_stall_cycles=1. With rs2_used=0 → no stall.
- MDU RAW:
  - Issue rd=9 → pending_cnt=1.
  - DEC reads x9 → stalls every cycle until the cycle after done(9), then releases; pending_cnt=0.
  - A DEC write of x9 while pending also stalls (WAW).
- Limit: MAX_PENDING=4 issues to x1–x4, then an MDU op in DEC → stalls. A same-cycle done(2) → no stall.
- Priority:
  - i_mem_stall with pc_src and load_use all high → four stalls=1, flushes=0.
  - Drop mem_stall → flush_dec=flush_exec=1, stalls=0.
- Errors and reset:
  - done(12) with bit 12 clear → o_sb_err=1, count unchanged.
  - Reset asserted in the same cycle as a valid done → all state 0 next cycle.
  - Counter at 0xFFFF with stall held → stays 0xFFFF; i_cnt_clr → 0.

Source files
------------

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage core: MEM/WB forwarding, load-use stall, branch flush,
// MDU register scoreboard with pending-op limit, D-cache freeze and a stall-cycle counter.
module hazard_unit_sb #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic                             i_clk,
    input  logic                             i_arst,
    input  logic [REG_ADDR_W-1:0]            i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0]            i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0]            i_rd_addr_dec,
    input  logic                             i_rs1_used_dec,
    input  logic                             i_rs2_used_dec,
    input  logic                             i_reg_we_dec,
    input  logic                             i_mdu_instr_dec,
    input  logic [REG_ADDR_W-1:0]            i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0]            i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0]            i_rd_addr_exec,
    input  logic                             i_load_instr_exec,
    input  logic                             i_mdu_issue_exec,
    input  logic [REG_ADDR_W-1:0]            i_rd_addr_mem,
    input  logic                             i_reg_we_mem,
    input  logic [REG_ADDR_W-1:0]            i_rd_addr_wb,
    input  logic                             i_reg_we_wb,
    input  logic                             i_pc_src_exec,
    input  logic                             i_mem_stall,
    input  logic                             i_mdu_done,
    input  logic [REG_ADDR_W-1:0]            i_mdu_rd_addr,
    input  logic                             i_cnt_clr,
    output logic                             o_stall_fetch,
    output logic                             o_stall_dec,
    output logic                             o_stall_exec,
    output logic                             o_stall_mem,
    output logic                             o_flush_dec,
    output logic                             o_flush_exec,
    output logic [1:0]                       o_forward_rs1,
    output logic [1:0]                       o_forward_rs2,
    output logic [$clog2(MAX_PENDING+1)-1:0] o_pending_cnt,
    output logic [CNT_W-1:0]                 o_stall_cycles,
    output logic                             o_sb_err
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PENDING);

    logic [NREG-1:0]  sb_q, sb_next;
    logic [PW-1:0]    cnt_q, cnt_next;
    logic [CNT_W-1:0] stall_cycles_q;
    logic             err_q, err_set;

    logic done_valid, issue_ev, issue_ok, cnt_full;
    logic rs1_sb, rs2_sb, rd_sb, load_use, raw_sb, waw_sb, full, hazard;

    assign cnt_full   = (cnt_q == MAX_CNT);
    assign done_valid = i_mdu_done & (i_mdu_rd_addr != '0) & sb_q[i_mdu_rd_addr];
    assign issue_ev   = i_mdu_issue_exec & ~i_mem_stall & (i_rd_addr_exec != '0);
    assign issue_ok   = issue_ev & ~cnt_full;

    // A DEC register is busy if an MDU op owns it, or one is issuing to it right now.
    assign rs1_sb = (i_rs1_addr_dec != '0) & (sb_q[i_rs1_addr_dec] |
                    (i_mdu_issue_exec & (i_rs1_addr_dec == i_rd_addr_exec)));
    assign rs2_sb = (i_rs2_addr_dec != '0) & (sb_q[i_rs2_addr_dec] |
                    (i_mdu_issue_exec & (i_rs2_addr_dec == i_rd_addr_exec)));
    assign rd_sb  = (i_rd_addr_dec != '0) & (sb_q[i_rd_addr_dec] |
                    (i_mdu_issue_exec & (i_rd_addr_dec == i_rd_addr_exec)));

    assign load_use = i_load_instr_exec & (i_rd_addr_exec != '0) &
                      ((i_rs1_used_dec & (i_rs1_addr_dec == i_rd_addr_exec)) |
                       (i_rs2_used_dec & (i_rs2_addr_dec == i_rd_addr_exec)));
    assign raw_sb   = (i_rs1_used_dec & rs1_sb) | (i_rs2_used_dec & rs2_sb);
    assign waw_sb   = i_reg_we_dec & rd_sb;
    assign full     = i_mdu_instr_dec & cnt_full & ~(i_mdu_done & done_valid);
    assign hazard   = load_use | raw_sb | waw_sb | full;

    always_comb begin
        o_forward_rs1 = 2'b00;
        o_forward_rs2 = 2'b00;
        if (i_reg_we_mem && i_rd_addr_mem == i_rs1_addr_exec && i_rd_addr_mem != '0)
            o_forward_rs1 = 2'b10;
        else if (i_reg_we_wb && i_rd_addr_wb == i_rs1_addr_exec && i_rd_addr_wb != '0)
            o_forward_rs1 = 2'b01;
        if (i_reg_we_mem && i_rd_addr_mem == i_rs2_addr_exec && i_rd_addr_mem != '0)
            o_forward_rs2 = 2'b10;
        else if (i_reg_we_wb && i_rd_addr_wb == i_rs2_addr_exec && i_rd_addr_wb != '0)
            o_forward_rs2 = 2'b01;
    end

    // Freeze beats branch, branch beats hazard.
    always_comb begin
        o_stall_fetch = 1'b0;
        o_stall_dec   = 1'b0;
        o_stall_exec  = 1'b0;
        o_stall_mem   = 1'b0;
        o_flush_dec   = 1'b0;
        o_flush_exec  = 1'b0;
        if (i_mem_stall) begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_stall_exec  = 1'b1;
            o_stall_mem   = 1'b1;
        end else if (i_pc_src_exec) begin
            o_flush_dec  = 1'b1;
            o_flush_exec = 1'b1;
        end else if (hazard) begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_flush_exec  = 1'b1;
        end
    end

    // Done is applied before issue so a same-register issue/done pair leaves the bit set.
    always_comb begin
        sb_next  = sb_q;
        cnt_next = cnt_q;
        err_set  = (i_mdu_done & ~done_valid) | (issue_ev & cnt_full);
        if (done_valid) sb_next[i_mdu_rd_addr] = 1'b0;
        if (issue_ok)   sb_next[i_rd_addr_exec] = 1'b1;
        case ({issue_ok, done_valid})
            2'b10:   cnt_next = cnt_q + PW'(1);
            2'b01:   cnt_next = cnt_q - PW'(1);
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            sb_q           <= '0;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            sb_q  <= sb_next;
            cnt_q <= cnt_next;
            if (err_set) err_q <= 1'b1;
            if (i_cnt_clr)
                stall_cycles_q <= '0;
            else if (o_stall_dec && !(&stall_cycles_q))
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign o_pending_cnt  = cnt_q;
    assign o_stall_cycles = stall_cycles_q;
    assign o_sb_err       = err_q;
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Scenario bench for hazard_unit_sb: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_hazard_unit_sb;
    localparam int AW = 5;
    localparam int MP = 4;
    localparam int CW = 8;
    localparam int PW = $clog2(MP + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst;
    logic [AW-1:0] rs1_dec, rs2_dec, rd_dec, rs1_exec, rs2_exec, rd_exec;
    logic [AW-1:0] rd_mem, rd_wb, mdu_rd;
    logic          rs1_used, rs2_used, we_dec, mdu_instr, load_exec, issue;
    logic          we_mem, we_wb, pc_src, mem_stall, mdu_done, cnt_clr;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]    fwd1, fwd2;
    logic [PW-1:0] pending;
    logic [CW-1:0] stall_cycles;
    logic          sb_err;

    logic [9:0]    ctl;
    logic [31:0]   exp_q[$];
    logic [31:0]   exp_w;
    logic [CW-1:0] exp_sc;
    int            n_checks = 0;
    int            n_pass = 0;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd1, fwd2};

    hazard_unit_sb #(.REG_ADDR_W(AW), .MAX_PENDING(MP), .CNT_W(CW)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec), .i_rd_addr_dec(rd_dec),
        .i_rs1_used_dec(rs1_used), .i_rs2_used_dec(rs2_used), .i_reg_we_dec(we_dec),
        .i_mdu_instr_dec(mdu_instr),
        .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec), .i_rd_addr_exec(rd_exec),
        .i_load_instr_exec(load_exec), .i_mdu_issue_exec(issue),
        .i_rd_addr_mem(rd_mem), .i_reg_we_mem(we_mem),
        .i_rd_addr_wb(rd_wb), .i_reg_we_wb(we_wb),
        .i_pc_src_exec(pc_src), .i_mem_stall(mem_stall),
        .i_mdu_done(mdu_done), .i_mdu_rd_addr(mdu_rd), .i_cnt_clr(cnt_clr),
        .o_stall_fetch(stall_f), .o_stall_dec(stall_d), .o_stall_exec(stall_e),
        .o_stall_mem(stall_m), .o_flush_dec(flush_d), .o_flush_exec(flush_e),
        .o_forward_rs1(fwd1), .o_forward_rs2(fwd2),
        .o_pending_cnt(pending), .o_stall_cycles(stall_cycles), .o_sb_err(sb_err)
    );

    task automatic idle();
        rs1_dec = '0; rs2_dec = '0; rd_dec = '0; rs1_exec = '0; rs2_exec = '0;
        rd_exec = '0; rd_mem = '0; rd_wb = '0; mdu_rd = '0;
        rs1_used = 0; rs2_used = 0; we_dec = 0; mdu_instr = 0; load_exec = 0;
        issue = 0; we_mem = 0; we_wb = 0; pc_src = 0; mem_stall = 0;
        mdu_done = 0; cnt_clr = 0;
    endtask

    // One clock; stall_exp is what the bench expects o_stall_dec to be this cycle.
    task automatic step(input bit stall_exp);
        @(posedge clk);
        if (arst || cnt_clr) exp_sc = '0;
        else if (stall_exp && exp_sc != {CW{1'b1}}) exp_sc = exp_sc + 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        arst = 1;
        step(0);
        step(0);
        arst = 0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL reset_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL reset_stall_cycles: got %0d want %0d", stall_cycles, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(sb_err) !== exp_w) $display("FAIL reset_sb_err: got %0d want %0d", sb_err, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL reset_ctl: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
    endtask

    task automatic test_forward();
        logic [1:0] e;
        rd_mem = 5; we_mem = 1; rd_wb = 5; we_wb = 1; rs1_exec = 5;
        exp_q.push_back(32'd2);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(fwd1) !== exp_w) $display("FAIL fwd_mem_wins: got %b want %b", fwd1, exp_w[1:0]); else n_pass++;
        we_mem = 0;
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(fwd1) !== exp_w) $display("FAIL fwd_wb: got %b want %b", fwd1, exp_w[1:0]); else n_pass++;
        we_mem = 1; rd_mem = 0; rd_wb = 0; rs1_exec = 0;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(fwd1) !== exp_w) $display("FAIL fwd_x0: got %b want %b", fwd1, exp_w[1:0]); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            rd_mem = AW'($urandom_range(0, 3)); rd_wb = AW'($urandom_range(0, 3));
            rs2_exec = AW'($urandom_range(0, 3));
            we_mem = 1'($urandom_range(0, 1)); we_wb = 1'($urandom_range(0, 1));
            if (we_mem && rd_mem == rs2_exec && rd_mem != 0) e = 2'b10;
            else if (we_wb && rd_wb == rs2_exec && rd_wb != 0) e = 2'b01;
            else e = 2'b00;
            exp_q.push_back(32'(e));
            #1;
            n_checks++; exp_w = exp_q.pop_front();
            if (32'(fwd2) !== exp_w) $display("FAIL fwd_rs2_rand: got %b want %b (mem %0d/%0d wb %0d/%0d rs2 %0d)",
                fwd2, exp_w[1:0], rd_mem, we_mem, rd_wb, we_wb, rs2_exec); else n_pass++;
        end
        idle();
    endtask

    task automatic test_load_use();
        load_exec = 1; rd_exec = 7; rs2_dec = 7; rs2_used = 1;
        exp_q.push_back(32'(10'b11_0001_0000));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL load_use_ctl: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
        step(1);
        idle();
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL load_use_count: got %0d want %0d", stall_cycles, exp_w); else n_pass++;
        load_exec = 1; rd_exec = 7; rs2_dec = 7; rs2_used = 0;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL load_unused_ctl: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
        step(0);
        idle();
    endtask

    task automatic test_mdu_raw();
        issue = 1; rd_exec = 9; rs1_dec = 9; rs1_used = 1;
        exp_q.push_back(32'(10'b11_0001_0000));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL raw_issue_same_cycle: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
        step(1);
        issue = 0; rd_exec = 0;
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL raw_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'd1);
            #1;
            n_checks++; exp_w = exp_q.pop_front();
            if (32'(stall_d) !== exp_w) $display("FAIL raw_hold: got %0d want %0d", stall_d, exp_w); else n_pass++;
            step(1);
        end
        rs1_used = 0; we_dec = 1; rd_dec = 9;
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL waw_stall: got %0d want %0d", stall_d, exp_w); else n_pass++;
        rd_dec = 0;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL waw_x0: got %0d want %0d", stall_d, exp_w); else n_pass++;
        we_dec = 0; rs1_used = 1; mdu_done = 1; mdu_rd = 9;
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL raw_done_cycle: got %0d want %0d", stall_d, exp_w); else n_pass++;
        step(1);
        mdu_done = 0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL raw_release: got %0d want %0d", stall_d, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL raw_pending_after: got %0d want %0d", pending, exp_w); else n_pass++;
        step(0);
        idle();
        exp_q.push_back(32'(exp_sc));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL raw_count: got %0d want %0d", stall_cycles, exp_w); else n_pass++;
    endtask

    task automatic test_limit();
        for (int r = 1; r <= MP; r++) begin
            issue = 1; rd_exec = AW'(r);
            step(0);
        end
        idle();
        exp_q.push_back(32'(MP));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL limit_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        mdu_instr = 1;
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL limit_full_stall: got %0d want %0d", stall_d, exp_w); else n_pass++;
        mdu_done = 1; mdu_rd = 2;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL limit_done_frees: got %0d want %0d", stall_d, exp_w); else n_pass++;
        step(0);
        mdu_instr = 0;
        mdu_rd = 1; step(0);
        mdu_rd = 3; step(0);
        mdu_rd = 4; step(0);
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL limit_drain: got %0d want %0d", pending, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(sb_err) !== exp_w) $display("FAIL limit_no_err: got %0d want %0d", sb_err, exp_w); else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue = 1; rd_exec = 3; step(0);
        rd_exec = 5; mdu_done = 1; mdu_rd = 3; step(0);
        idle();
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL b2b_diff_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        rs1_dec = 3; rs1_used = 1;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL b2b_cleared_bit: got %0d want %0d", stall_d, exp_w); else n_pass++;
        idle();
        issue = 1; rd_exec = 5; mdu_done = 1; mdu_rd = 5; step(0);
        idle();
        rs2_dec = 5; rs2_used = 1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL b2b_same_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL b2b_same_bit_set: got %0d want %0d", stall_d, exp_w); else n_pass++;
        idle();
        mdu_done = 1; mdu_rd = 5; step(0);
        idle();
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL b2b_final_pending: got %0d want %0d", pending, exp_w); else n_pass++;
    endtask

    task automatic test_priority();
        mem_stall = 1; pc_src = 1; load_exec = 1; rd_exec = 7; rs2_dec = 7; rs2_used = 1;
        exp_q.push_back(32'(10'b11_1100_0000));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL prio_freeze: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
        step(1);
        mem_stall = 0;
        exp_q.push_back(32'(10'b00_0011_0000));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(ctl) !== exp_w) $display("FAIL prio_branch: got %b want %b", ctl, exp_w[9:0]); else n_pass++;
        step(0);
        idle();
        exp_q.push_back(32'(exp_sc));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL prio_count: got %0d want %0d", stall_cycles, exp_w); else n_pass++;
    endtask

    task automatic test_errors();
        mdu_done = 1; mdu_rd = 12; step(0);
        idle();
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(sb_err) !== exp_w) $display("FAIL err_spurious_done: got %0d want %0d", sb_err, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL err_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        issue = 1; rd_exec = 12; step(0);
        idle();
        exp_q.push_back(32'd1);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL err_issue12: got %0d want %0d", pending, exp_w); else n_pass++;
        mdu_done = 1; mdu_rd = 12; arst = 1; step(0);
        arst = 0; idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(pending) !== exp_w) $display("FAIL rst_pending: got %0d want %0d", pending, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(sb_err) !== exp_w) $display("FAIL rst_sb_err: got %0d want %0d", sb_err, exp_w); else n_pass++;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL rst_stall_cycles: got %0d want %0d", stall_cycles, exp_w); else n_pass++;
        rs1_dec = 12; rs1_used = 1;
        exp_q.push_back(32'd0);
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_d) !== exp_w) $display("FAIL rst_sb_cleared: got %0d want %0d", stall_d, exp_w); else n_pass++;
        idle();
    endtask

    task automatic test_saturate();
        mem_stall = 1;
        repeat (300) step(1);
        exp_q.push_back(32'(exp_sc));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL sat_hold: got %0h want %0h", stall_cycles, exp_w); else n_pass++;
        cnt_clr = 1;
        step(1);
        idle();
        exp_q.push_back(32'(exp_sc));
        #1;
        n_checks++; exp_w = exp_q.pop_front();
        if (32'(stall_cycles) !== exp_w) $display("FAIL sat_clear: got %0h want %0h", stall_cycles, exp_w); else n_pass++;
    endtask

    initial begin
        exp_sc = '0;
        arst = 1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_mdu_raw();
        test_limit();
        test_back_to_back();
        test_priority();
        test_errors();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
